// File: rtl/dco_loop_filter_pkg.sv
// Shared ADPLL constants: default loop-filter geometry and midscale helpers used by the
// loop filter and the ring oscillator it steers.
package dco_loop_filter_pkg;

  localparam int unsigned CtrlWidthDef  = 4;
  localparam int unsigned IntWidthDef   = 10;
  localparam int unsigned LockCountDef  = 16;
  localparam int unsigned KpStepDef     = 1;
  // Update strobes are blocked for this many cycles after each accepted reference edge.
  localparam int unsigned HoldoffCycles = 2;

  localparam int unsigned CtrlMidDef = 1 << (CtrlWidthDef - 1);
  localparam int unsigned IntMidDef  = 1 << (IntWidthDef - 1);

  function automatic int unsigned midscale(input int unsigned width);
    return 1 << (width - 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous control bit.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/dco_loop_filter.sv
// Bang-bang PI loop filter: integrates PD decisions on each reference edge, adds a
// proportional kick and drives the ring-oscillator frequency code; flags lock on alternation.
module dco_loop_filter
  import dco_loop_filter_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH = CtrlWidthDef,
  parameter int unsigned INT_WIDTH  = IntWidthDef,
  parameter int unsigned KP_STEP    = KpStepDef,
  parameter int unsigned LOCK_COUNT = LockCountDef
) (
  input  logic                  fpga_clk_i,
  input  logic                  rst_n_i,
  input  logic                  enable_i,
  input  logic                  ref_i,
  input  logic                  pd_i,
  output logic [CTRL_WIDTH-1:0] freq_code_o,
  output logic                  update_o,
  output logic                  lock_o
);

  localparam int unsigned Shift = INT_WIDTH - CTRL_WIDTH;
  localparam int unsigned CntW  = $clog2(LOCK_COUNT + 1);
  localparam int          CodeMax = (1 << CTRL_WIDTH) - 1;

  localparam logic [INT_WIDTH-1:0]  IntMax  = '1;
  localparam logic [INT_WIDTH-1:0]  IntMid  = INT_WIDTH'(midscale(INT_WIDTH));
  localparam logic [CTRL_WIDTH-1:0] CodeMid = CTRL_WIDTH'(midscale(CTRL_WIDTH));
  localparam logic [CntW-1:0]       LockCnt = CntW'(LOCK_COUNT);

  logic ref_s2, pd_s2, upd;
  logic ref_s3_q;
  logic [INT_WIDTH-1:0]  integ_q, integ_d;
  logic [CTRL_WIDTH-1:0] code_q, code_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            hold_q, hold_d;
  logic                  prev_q, prev_d;
  logic                  first_q, first_d;
  logic                  upd_q;
  int                    code_tmp;

  sync_2ff u_ref_sync (
    .clk_i  (fpga_clk_i),
    .rst_ni (rst_n_i),
    .d_i    (ref_i),
    .q_o    (ref_s2)
  );

  sync_2ff u_pd_sync (
    .clk_i  (fpga_clk_i),
    .rst_ni (rst_n_i),
    .d_i    (pd_i),
    .q_o    (pd_s2)
  );

  assign upd = ref_s2 & ~ref_s3_q & enable_i & (hold_q == 2'd0);

  always_comb begin
    integ_d  = integ_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    first_d  = first_q;
    hold_d   = (hold_q != 2'd0) ? hold_q - 2'd1 : 2'd0;
    code_tmp = 0;

    if (upd) begin
      hold_d = 2'(HoldoffCycles);
      if (pd_s2) integ_d = (integ_q == IntMax) ? integ_q : integ_q + INT_WIDTH'(1);
      else       integ_d = (integ_q == '0)     ? integ_q : integ_q - INT_WIDTH'(1);

      code_tmp = int'(integ_d >> Shift) + (pd_s2 ? int'(KP_STEP) : -int'(KP_STEP));
      if (code_tmp < 0)            code_d = '0;
      else if (code_tmp > CodeMax) code_d = '1;
      else                         code_d = CTRL_WIDTH'(code_tmp);

      // The first decision has no predecessor, so it cannot count as an alternation.
      if (first_q)              cnt_d = '0;
      else if (pd_s2 != prev_q) cnt_d = (cnt_q == LockCnt) ? cnt_q : cnt_q + CntW'(1);
      else                      cnt_d = '0;
      prev_d  = pd_s2;
      first_d = 1'b0;
    end

    if (!enable_i) begin
      cnt_d   = '0;
      first_d = 1'b1;
    end
  end

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ref_s3_q <= 1'b0;
      integ_q  <= IntMid;
      code_q   <= CodeMid;
      cnt_q    <= '0;
      hold_q   <= 2'd0;
      prev_q   <= 1'b0;
      first_q  <= 1'b1;
      upd_q    <= 1'b0;
    end else begin
      ref_s3_q <= ref_s2;
      integ_q  <= integ_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      prev_q   <= prev_d;
      first_q  <= first_d;
      upd_q    <= upd;
    end
  end

  assign freq_code_o = code_q;
  assign update_o    = upd_q;
  assign lock_o      = (cnt_q == LockCnt);

endmodule

// File: tb/tb_dco_loop_filter.sv
// Scoreboard bench for dco_loop_filter: a behavioural model queues the expected result of
// each reference edge and a monitor checks it whenever update_o pulses.
module tb_dco_loop_filter;

  typedef struct {
    logic [3:0] code;
    logic       lock;
    logic [9:0] integ;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       ref_in = 1'b0;
  logic       pd_in = 1'b0;
  logic [3:0] freq_code;
  logic       update;
  logic       lock;

  int   n_cmp = 0;
  int   n_err = 0;
  int   upd_seen = 0;
  exp_t sb[$];

  int m_int, m_cnt;
  bit m_prev, m_first;

  always #3 clk = ~clk;

  dco_loop_filter dut (
    .fpga_clk_i  (clk),
    .rst_n_i     (rst_n),
    .enable_i    (en),
    .ref_i       (ref_in),
    .pd_i        (pd_in),
    .freq_code_o (freq_code),
    .update_o    (update),
    .lock_o      (lock)
  );

  always @(negedge clk) begin
    if (rst_n && update) begin
      exp_t e;
      upd_seen++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL spurious_update: update_o=1 required no update");
      end else begin
        e = sb.pop_front();
        if (freq_code !== e.code || lock !== e.lock || dut.integ_q !== e.integ) begin
          n_err++;
          $display("FAIL update_result: code=%0d lock=%0b integ=%0d required code=%0d lock=%0b integ=%0d",
                   freq_code, lock, dut.integ_q, e.code, e.lock, e.integ);
        end
      end
    end
  end

  task automatic model_reset();
    m_int = 512; m_cnt = 0; m_prev = 0; m_first = 1;
    sb.delete();
  endtask

  task automatic model_update(input bit d);
    exp_t e;
    int   c;
    if (d) m_int = (m_int == 1023) ? 1023 : m_int + 1;
    else   m_int = (m_int == 0) ? 0 : m_int - 1;
    c = (m_int >> 6) + (d ? 1 : -1);
    if (c < 0) c = 0;
    if (c > 15) c = 15;
    if (m_first)        m_cnt = 0;
    else if (d != m_prev) m_cnt = (m_cnt == 16) ? 16 : m_cnt + 1;
    else                m_cnt = 0;
    m_first = 0;
    m_prev  = d;
    e.code = 4'(c); e.lock = (m_cnt == 16); e.integ = 10'(m_int);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ref_in = 1'b0; pd_in = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a falling edge; leaves enough low time for the update to retire.
  task automatic send_edge(input bit d);
    pd_in = d; ref_in = 1'b1;
    if (en) model_update(d);
    repeat (4) @(negedge clk);
    ref_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_drained: %0d pending updates, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    en = 1'b1;
    do_reset();
    n_cmp++;
    if (freq_code !== 4'd8 || lock !== 1'b0 || update !== 1'b0 || dut.integ_q !== 10'd512) begin
      n_err++;
      $display("FAIL reset_state: code=%0d lock=%0b upd=%0b integ=%0d required 8/0/0/512",
               freq_code, lock, update, dut.integ_q);
    end
  endtask

  task automatic test_latency();
    logic [3:0] want [5] = '{4'd8, 4'd8, 4'd9, 4'd9, 4'd9};
    logic       wupd [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    pd_in = 1'b1; ref_in = 1'b1;
    model_update(1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (freq_code !== want[i] || update !== wupd[i]) begin
        n_err++;
        $display("FAIL latency_edge%0d: code=%0d upd=%0b required code=%0d upd=%0b",
                 i + 1, freq_code, update, want[i], wupd[i]);
      end
    end
    @(negedge clk);
    ref_in = 1'b0;
    repeat (4) @(negedge clk);
    check_drained("latency");
  endtask

  task automatic test_monotone();
    do_reset();
    for (int i = 0; i < 10; i++) send_edge(1'b1);
    n_cmp++;
    if (dut.integ_q !== 10'd522 || freq_code !== 4'd9) begin
      n_err++;
      $display("FAIL monotone: integ=%0d code=%0d required 522/9", dut.integ_q, freq_code);
    end
    check_drained("monotone");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 600; i++) send_edge(1'b1);
    n_cmp++;
    if (dut.integ_q !== 10'd1023 || freq_code !== 4'd15) begin
      n_err++;
      $display("FAIL sat_high: integ=%0d code=%0d required 1023/15", dut.integ_q, freq_code);
    end
    send_edge(1'b0);
    n_cmp++;
    if (dut.integ_q !== 10'd1022 || freq_code !== 4'd14) begin
      n_err++;
      $display("FAIL sat_step_down: integ=%0d code=%0d required 1022/14", dut.integ_q, freq_code);
    end
    check_drained("saturation");
  endtask

  task automatic test_lock();
    bit d;
    do_reset();
    d = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      d = ~d;
      send_edge(d);
      if (i == 16 || i == 17) begin
        n_cmp++;
        if (lock !== (i == 17)) begin
          n_err++;
          $display("FAIL lock_after_%0d: lock=%0b required %0b", i, lock, (i == 17));
        end
      end
    end
    send_edge(d);
    n_cmp++;
    if (lock !== 1'b0) begin
      n_err++;
      $display("FAIL lock_drop: lock=%0b required 0", lock);
    end
    check_drained("lock");
  endtask

  task automatic test_enable();
    logic [3:0] code0;
    int         seen0;
    bit         d;
    // Rebuild lock first so disabling has something to clear.
    d = 1'b0;
    for (int i = 0; i < 18; i++) begin
      d = ~d;
      send_edge(d);
    end
    en = 1'b0; m_cnt = 0; m_first = 1;
    @(negedge clk);
    code0 = freq_code;
    seen0 = upd_seen;
    n_cmp++;
    if (lock !== 1'b0) begin
      n_err++;
      $display("FAIL enable_lock_clear: lock=%0b required 0", lock);
    end
    for (int i = 0; i < 20; i++) send_edge(i[0]);
    n_cmp++;
    if (freq_code !== code0 || upd_seen != seen0 || lock !== 1'b0) begin
      n_err++;
      $display("FAIL enable_hold: code=%0d updates=%0d lock=%0b required code=%0d updates=0 lock=0",
               freq_code, upd_seen - seen0, lock, code0);
    end
    en = 1'b1;
    @(negedge clk);
    send_edge(~d);
    send_edge(d);
    check_drained("enable");
  endtask

  task automatic test_back_to_back();
    int seen0;
    seen0 = upd_seen;
    pd_in = 1'b1;
    ref_in = 1'b1; model_update(1'b1);
    @(negedge clk); ref_in = 1'b0;
    @(negedge clk); ref_in = 1'b1;
    @(negedge clk); ref_in = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (upd_seen - seen0 != 1) begin
      n_err++;
      $display("FAIL back_to_back: updates=%0d required 1", upd_seen - seen0);
    end
    send_edge(1'b0);
    check_drained("back_to_back");
  endtask

  task automatic test_reset_midrun();
    int seen0;
    send_edge(1'b1);
    ref_in = 1'b1; pd_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; ref_in = 1'b0;
    #1;
    n_cmp++;
    if (freq_code !== 4'd8 || lock !== 1'b0 || update !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midrun: code=%0d lock=%0b upd=%0b required 8/0/0",
               freq_code, lock, update);
    end
    model_reset();
    repeat (2) @(negedge clk);
    seen0 = upd_seen;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (upd_seen != seen0 || dut.integ_q !== 10'd512) begin
      n_err++;
      $display("FAIL reset_discard: updates=%0d integ=%0d required 0/512",
               upd_seen - seen0, dut.integ_q);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_monotone();
    test_saturation();
    test_lock();
    test_enable();
    test_back_to_back();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
